// File: rtl/alu_cmd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer_pkg
// Shared definitions for the ALU command sequencer:
//   - ALU function select codes (ADD/SUB/MUL/DIV)
//   - default opcode base byte (only bits [7:2] are significant)
//   - sequencer state encoding
//   - the fixed result reported for a divide by zero
//   - a helper that recognises the divide-by-zero case
// -----------------------------------------------------------------------------
package alu_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        FUN_ADD = 2'b00,
        FUN_SUB = 2'b01,
        FUN_MUL = 2'b10,
        FUN_DIV = 2'b11
    } alu_fun_e;

    localparam logic [7:0]  OPC_BASE_DEFAULT = 8'hA0;
    localparam logic [15:0] DIV0_RESULT      = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_A   = 3'd1,
        ST_GET_B   = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_SEND_LO = 3'd5,
        ST_SEND_HI = 3'd6
    } state_e;

    // True when the command would divide by zero and must bypass the ALU.
    function automatic logic is_div0(input logic [1:0] fun, input logic [7:0] b);
        return (fun == FUN_DIV) && (b == 8'h00);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Receives three-byte command frames (opcode, A, B) from a byte receiver,
// issues one operation to an external registered arithmetic unit, waits for
// its result (with timeout) and returns the 16-bit result to a transmitter as
// two bytes, low byte first, using a valid/ready handshake.
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_rx_data    received command byte
//   i_rx_valid   one-cycle strobe qualifying i_rx_data
//   o_alu_a/b    operands to the arithmetic unit
//   o_alu_fun    op select: 00 ADD, 01 SUB, 10 MUL, 11 DIV
//   o_alu_en     one-cycle enable per issued command
//   i_alu_out    registered arithmetic result
//   i_alu_flag   result valid, expected the cycle after o_alu_en
//   o_tx_data    result byte to transmitter
//   o_tx_valid   o_tx_data valid, held until accepted
//   i_tx_ready   transmitter accepts the byte when high with o_tx_valid
//   o_busy       high in every state except IDLE
//   o_err        one-cycle pulse on any error event
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4,
    parameter logic [7:0]  OPC_BASE       = OPC_BASE_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_alu_a,
    output logic [7:0]  o_alu_b,
    output logic [1:0]  o_alu_fun,
    output logic        o_alu_en,
    input  logic [15:0] i_alu_out,
    input  logic        i_alu_flag,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_err
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e           r_state;
    logic [7:0]       r_alu_a;
    logic [7:0]       r_alu_b;
    logic [1:0]       r_alu_fun;
    logic             r_alu_en;
    logic [15:0]      r_result;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic             r_busy;
    logic             r_err;

    logic w_opc_valid;
    logic w_div0_on_b;   // divide by zero detected while B is arriving
    logic w_div0;        // divide by zero with B already latched

    assign w_opc_valid = (i_rx_data[7:2] == OPC_BASE[7:2]);
    assign w_div0_on_b = is_div0(r_alu_fun, i_rx_data);
    assign w_div0      = is_div0(r_alu_fun, r_alu_b);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_alu_a    <= 8'h00;
            r_alu_b    <= 8'h00;
            r_alu_fun  <= 2'b00;
            r_alu_en   <= 1'b0;
            r_result   <= 16'h0000;
            r_tmo      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Pulsed outputs default low; every error source below only ever
            // sets r_err, so coincident events merge into one pulse.
            r_alu_en <= 1'b0;
            r_err    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        if (w_opc_valid) begin
                            r_alu_fun <= i_rx_data[1:0];
                            r_state   <= ST_GET_A;
                            r_busy    <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                ST_GET_A: begin
                    if (i_rx_valid) begin
                        r_alu_a <= i_rx_data;
                        r_state <= ST_GET_B;
                    end
                end

                ST_GET_B: begin
                    if (i_rx_valid) begin
                        r_alu_b <= i_rx_data;
                        r_state <= ST_ISSUE;
                        // Outputs are registered, so the ISSUE-cycle decision
                        // is made here from the incoming B byte: the enable
                        // (or the error pulse) is then visible during ISSUE.
                        if (w_div0_on_b) begin
                            r_err <= 1'b1;
                        end else begin
                            r_alu_en <= 1'b1;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (i_rx_valid) begin
                        r_err <= 1'b1;
                    end
                    if (w_div0) begin
                        r_result   <= DIV0_RESULT;
                        r_tx_data  <= DIV0_RESULT[7:0];
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_SEND_LO;
                    end else begin
                        r_tmo   <= '0;
                        r_state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (i_rx_valid) begin
                        r_err <= 1'b1;
                    end
                    if (i_alu_flag) begin
                        r_result   <= i_alu_out;
                        r_tx_data  <= i_alu_out[7:0];
                        r_tx_valid <= 1'b1;
                        r_tmo      <= '0;
                        r_state    <= ST_SEND_LO;
                    end else if (r_tmo == TMO_LAST) begin
                        // Abort: the frame is discarded, nothing is sent.
                        r_err   <= 1'b1;
                        r_tmo   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                ST_SEND_LO: begin
                    if (i_rx_valid) begin
                        r_err <= 1'b1;
                    end
                    if (i_tx_ready) begin
                        r_tx_data <= r_result[15:8];
                        r_state   <= ST_SEND_HI;
                    end
                end

                ST_SEND_HI: begin
                    if (i_rx_valid) begin
                        r_err <= 1'b1;
                    end
                    if (i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= 8'h00;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_fun  = r_alu_fun;
    assign o_alu_en   = r_alu_en;
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;
    assign o_err      = r_err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Directed frames drive the sequencer; expected ALU commands and TX bytes are
// queued at stimulus time and a negedge monitor pops and compares them as the
// DUT presents o_alu_en pulses and TX handshakes. A small ALU model answers
// each enable with a preset result one cycle later.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [1:0]  alu_fun;
    logic        alu_en;
    logic [15:0] alu_out;
    logic        alu_flag;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .TIMEOUT_CYCLES(4),
        .OPC_BASE      (8'hA0)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_rx_data (rx_data),
        .i_rx_valid(rx_valid),
        .o_alu_a   (alu_a),
        .o_alu_b   (alu_b),
        .o_alu_fun (alu_fun),
        .o_alu_en  (alu_en),
        .i_alu_out (alu_out),
        .i_alu_flag(alu_flag),
        .o_tx_data (tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready),
        .o_busy    (busy),
        .o_err     (err)
    );

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int en_cnt = 0;

    logic [17:0] exp_alu_q[$];   // {fun, a, b}
    logic [7:0]  exp_tx_q[$];

    logic        alu_respond = 1'b1;
    logic [15:0] alu_resp = 16'h0000;
    logic        en_s;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ALU model: result and flag appear the cycle after an enable.
    initial begin
        alu_flag = 1'b0;
        alu_out  = 16'h0000;
        forever begin
            @(negedge clk);
            en_s = alu_en;
            @(posedge clk);
            #1;
            if (en_s && alu_respond) begin
                alu_flag = 1'b1;
                alu_out  = alu_resp;
            end else begin
                alu_flag = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [17:0] exp_cmd;
        logic [7:0]  exp_byte;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (alu_en) begin
                    en_cnt++;
                    checks++;
                    if (exp_alu_q.size() == 0) begin
                        errors++;
                        $display("FAIL alu_en_unexpected actual=%0h required=none", {alu_fun, alu_a, alu_b});
                    end else begin
                        checks--;
                        exp_cmd = exp_alu_q.pop_front();
                        check("alu_cmd", {14'd0, alu_fun, alu_a, alu_b}, {14'd0, exp_cmd});
                    end
                end
                if (err) err_cnt++;
                if (prev_hold) begin
                    check("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
                    check("tx_hold_data", {24'd0, tx_data}, {24'd0, prev_data});
                end
                if (tx_valid && tx_ready) begin
                    checks++;
                    if (exp_tx_q.size() == 0) begin
                        errors++;
                        $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
                    end else begin
                        checks--;
                        exp_byte = exp_tx_q.pop_front();
                        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_byte});
                        $display("TX byte %02h expected %02h", tx_data, exp_byte);
                    end
                end
                prev_hold = tx_valid && !tx_ready;
                prev_data = tx_data;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        send_byte(op);
        send_byte(a);
        send_byte(b);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
        tick();
        tick();
    endtask

    task automatic wait_tx_valid(input string name);
        int n = 0;
        while (!tx_valid && n < 20) begin
            tick();
            n++;
        end
        check(name, {31'd0, tx_valid}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_a"},    {24'd0, alu_a},   32'd0);
        check({tag, "_alu_b"},    {24'd0, alu_b},   32'd0);
        check({tag, "_alu_fun"},  {30'd0, alu_fun}, 32'd0);
        check({tag, "_alu_en"},   {31'd0, alu_en},  32'd0);
        check({tag, "_tx_data"},  {24'd0, tx_data}, 32'd0);
        check({tag, "_tx_valid"}, {31'd0, tx_valid},32'd0);
        check({tag, "_busy"},     {31'd0, busy},    32'd0);
        check({tag, "_err"},      {31'd0, err},     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int n0;
        int n;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // ADD 12+34 -> 0046
        e0 = err_cnt; n0 = en_cnt;
        alu_resp = 16'h0046;
        exp_alu_q.push_back({2'b00, 8'h12, 8'h34});
        exp_tx_q.push_back(8'h46);
        exp_tx_q.push_back(8'h00);
        send_frame(8'hA0, 8'h12, 8'h34);
        @(negedge clk);
        check("add_en_latency", {31'd0, alu_en}, 32'd1);
        check("add_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("add_tx_latency", {31'd0, tx_valid}, 32'd1);
        wait_idle("add_idle");
        check("add_err", err_cnt - e0, 32'd0);
        check("add_en_count", en_cnt - n0, 32'd1);
        $display("frame A0 12 34 done");

        // MUL FF*FF -> FE01
        e0 = err_cnt;
        alu_resp = 16'hFE01;
        exp_alu_q.push_back({2'b10, 8'hFF, 8'hFF});
        exp_tx_q.push_back(8'h01);
        exp_tx_q.push_back(8'hFE);
        send_frame(8'hA2, 8'hFF, 8'hFF);
        wait_idle("mul_idle");
        check("mul_err", err_cnt - e0, 32'd0);
        $display("frame A2 FF FF done");

        // DIV by zero: no enable, error in ISSUE, FFFF returned
        e0 = err_cnt; n0 = en_cnt;
        exp_tx_q.push_back(8'hFF);
        exp_tx_q.push_back(8'hFF);
        send_frame(8'hA3, 8'h10, 8'h00);
        @(negedge clk);
        check("div0_err_in_issue", {31'd0, err}, 32'd1);
        check("div0_no_en", {31'd0, alu_en}, 32'd0);
        wait_idle("div0_idle");
        check("div0_err_count", err_cnt - e0, 32'd1);
        check("div0_en_count", en_cnt - n0, 32'd0);
        $display("frame A3 10 00 done");

        // Invalid opcode in IDLE
        e0 = err_cnt;
        send_byte(8'h55);
        @(negedge clk);
        check("badop_err", {31'd0, err}, 32'd1);
        check("badop_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        check("badop_err_count", err_cnt - e0, 32'd1);
        $display("opcode 55 done");

        // Strobe during WAIT: dropped with error, result still sent
        e0 = err_cnt;
        alu_resp = 16'h000C;
        exp_alu_q.push_back({2'b00, 8'h05, 8'h07});
        exp_tx_q.push_back(8'h0C);
        exp_tx_q.push_back(8'h00);
        send_frame(8'hA0, 8'h05, 8'h07);
        tick();
        send_byte(8'h77);
        wait_idle("waitstrobe_idle");
        check("waitstrobe_err_count", err_cnt - e0, 32'd1);
        $display("strobe during WAIT done");

        // Back-pressure: TX_READY low 10 cycles in SEND_LO
        alu_resp = 16'h0042;
        tx_ready = 1'b0;
        exp_alu_q.push_back({2'b00, 8'h20, 8'h22});
        exp_tx_q.push_back(8'h42);
        exp_tx_q.push_back(8'h00);
        send_frame(8'hA0, 8'h20, 8'h22);
        wait_tx_valid("hold_valid_seen");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_lo_data", {24'd0, tx_data}, 32'h42);
        end
        tick();
        tx_ready = 1'b1;
        wait_idle("hold_idle");
        $display("back-pressure frame done");

        // ALU never answers: timeout after 4 WAIT cycles
        e0 = err_cnt;
        alu_respond = 1'b0;
        exp_alu_q.push_back({2'b00, 8'h01, 8'h01});
        send_frame(8'hA0, 8'h01, 8'h01);
        n = 0;
        while (!err && n < 20) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 32'd5);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_no_tx", {31'd0, tx_valid}, 32'd0);
        alu_respond = 1'b1;
        tick();
        tick();
        check("timeout_err_count", err_cnt - e0, 32'd1);
        $display("timeout frame done");

        // Reset during SEND_HI with TX_READY low
        alu_resp = 16'h5A09;
        tx_ready = 1'b0;
        exp_alu_q.push_back({2'b10, 8'h03, 8'h03});
        exp_tx_q.push_back(8'h09);
        send_frame(8'hA2, 8'h03, 8'h03);
        wait_tx_valid("rst_valid_seen");
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("rst_hi_byte", {24'd0, tx_data}, 32'h5A);
        rst_n    = 1'b0;
        tx_ready = 1'b1;
        tick();
        check_all_zero("midrst");
        rst_n = 1'b1;
        tick();

        // Fresh frame after reset: SUB 09-04 -> 0005
        alu_resp = 16'h0005;
        exp_alu_q.push_back({2'b01, 8'h09, 8'h04});
        exp_tx_q.push_back(8'h05);
        exp_tx_q.push_back(8'h00);
        send_frame(8'hA1, 8'h09, 8'h04);
        wait_idle("postrst_idle");
        $display("frame A1 09 04 done");

        check("alu_queue_drained", exp_alu_q.size(), 32'd0);
        check("tx_queue_drained", exp_tx_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4: maximum WAIT cycles for ALU_FLAG before abort.
REQ-002 Parameter OPC_BASE, default 8'hA0: upper six bits of a valid opcode byte.
REQ-003 CLK  in  1  sole clock; all logic on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-low.
REQ-005 RX_DATA  in  8  received command byte.
REQ-006 RX_VALID  in  1  one-cycle strobe; RX_DATA valid.
REQ-007 ALU_A  out  8  operand A to arithmetic unit.
REQ-008 ALU_B  out  8  operand B to arithmetic unit.
REQ-009 ALU_FUN  out  2  op select: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-010 ALU_EN  out  1  arithmetic enable, one-cycle pulse per command.
REQ-011 ALU_OUT  in  16  registered arithmetic result.
REQ-012 ALU_FLAG  in  1  result valid, high the cycle after ALU_EN.
REQ-013 TX_DATA  out  8  result byte to transmitter.
REQ-014 TX_VALID  out  1  TX_DATA valid; held until accepted.
REQ-015 TX_READY  in  1  transmitter accepts byte when high with TX_VALID.
REQ-016 BUSY  out  1  high in every state except IDLE.
REQ-017 ERR  out  1  one-cycle pulse on any error event.

Function
REQ-018 Command frame SHALL be three RX bytes: opcode, A, B; opcode valid iff RX_DATA[7:2] == OPC_BASE[7:2], ALU_FUN = RX_DATA[1:0].
REQ-019 States SHALL be IDLE, GET_A, GET_B, ISSUE, WAIT, SEND_LO, SEND_HI.
REQ-020 IDLE: valid opcode strobe -> GET_A, latch FUN; invalid opcode strobe -> ERR pulse, stay IDLE.
REQ-021 GET_A: strobe -> latch A, GET_B; GET_B: strobe -> latch B, ISSUE.
REQ-022 ISSUE (one cycle): if FUN==DIV and B==0, load result 16'hFFFF, pulse ERR, go SEND_LO without ALU_EN; else ALU_EN=1 for exactly this cycle, go WAIT.
REQ-023 ALU_A, ALU_B, ALU_FUN SHALL hold latched values from ISSUE through WAIT exit.
REQ-024 WAIT: ALU_FLAG high -> capture ALU_OUT, go SEND_LO; after TIMEOUT_CYCLES cycles without flag -> ERR pulse, IDLE, nothing sent.
REQ-025 SEND_LO drives result[7:0], SEND_HI drives result[15:8], TX_VALID=1 in both; advance only on cycle with TX_VALID&&TX_READY; SEND_HI handshake -> IDLE.
REQ-026 TX_DATA SHALL remain stable while TX_VALID high and TX_READY low.
REQ-027 RX_VALID strobes in ISSUE, WAIT, SEND_LO, SEND_HI SHALL be dropped with ERR pulse; state unaffected.
REQ-028 Command latency: ALU_EN asserts in the cycle after the B strobe; TX_VALID for low byte asserts the cycle after ALU_FLAG.
REQ-029 ERR events coinciding in one cycle SHALL produce a single one-cycle pulse.

Reset
REQ-030 RST low at a rising edge SHALL force IDLE and zero ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, BUSY, ERR, captured result, timeout counter.
REQ-031 Reset mid-frame or mid-handshake SHALL discard the frame; TX_VALID low the cycle after reset even if TX_READY high.

Structure
REQ-032 Shared package SHALL hold ALU_FUN codes (ADD/SUB/MUL/DIV), OPC_BASE default, state encoding, and DIV0_RESULT=16'hFFFF.
REQ-033 Single module, no sub-module; one FSM plus timeout counter and result register.

Verification
REQ-034 RX A0,12,34; ALU returns 0x0046 -> ALU_EN one pulse, ALU_FUN=00, TX bytes 46 then 00, BUSY low after.
REQ-035 RX A2,FF,FF; ALU returns 0xFE01 -> TX 01 then FE.
REQ-036 RX A3,10,00 -> no ALU_EN, ERR pulse in ISSUE, TX FF then FF.
REQ-037 RX 55 in IDLE -> ERR pulse, BUSY stays low; strobe during WAIT -> ERR, result still sent.
REQ-038 TX_READY low 10 cycles in SEND_LO -> TX_DATA/TX_VALID stable; ALU_FLAG never returned -> ERR after 4 WAIT cycles, IDLE.
REQ-039 RST low during SEND_HI with TX_READY low -> next cycle all outputs 0, state IDLE; new frame A1,09,04 then completes normally.
